// File: rtl/io_pkg.sv
// Shared types and constants for the seven-segment display engine.
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } hexdisp_state_t;

    // Active-high gfedcba patterns for 0..F
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // ceil(w * log10(2)) with integer arithmetic
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// One 4-bit digit to a seven-segment pattern, with blanking and polarity select.
module hex_to_seg7
    import io_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    assign seg_hi = blank ? 7'h00 : SEG7_LUT[digit];
    assign seg    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/io_hex_display.sv
// Memory-mapped seven-segment display engine: HEX or double-dabble decimal
// conversion with leading-zero blanking and a one-deep pending write buffer.
//
// state   | meaning
// IDLE    | waiting for a write or a pending tuple
// CONV    | one double-dabble step per cycle, DATA_W steps total
// UPDATE  | register segments, pulse done, return to IDLE
module io_hex_display
    import io_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NUM_DIGITS     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_dec,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS*7-1:0] hex_out,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int WIDE_W     = DISP_W + BCD_W + DATA_W;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    hexdisp_state_t state, state_nxt;

    logic [DATA_W-1:0] data_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  cnt;
    logic              cur_dec;
    logic              cur_blank;

    logic              pend_vld;
    logic [DATA_W-1:0] pend_data;
    logic              pend_dec;
    logic              pend_blank;

    logic              ld;
    logic [DATA_W-1:0] ld_data;
    logic              ld_dec;
    logic              ld_blank;
    logic              pend_wr;
    logic              pend_vld_nxt;
    logic              busy_nxt;

    logic [WIDE_W-1:0]       wide;
    logic [DISP_W-1:0]       dig_vec;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS*7-1:0] seg_vec;
    logic                    ovf_dec;
    logic                    lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_data   = wr_data;
        ld_dec    = wr_dec;
        ld_blank  = blank_lz;
        pend_wr   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Pending tuple wins; a coincident write replaces it in the buffer
                if (pend_vld) begin
                    ld       = 1'b1;
                    ld_data  = pend_data;
                    ld_dec   = pend_dec;
                    ld_blank = pend_blank;
                    pend_wr  = wr_en;
                end else if (wr_en) begin
                    ld = 1'b1;
                end
                if (ld) state_nxt = ld_dec ? ST_CONV : ST_UPDATE;
            end
            ST_CONV: begin
                pend_wr = wr_en;
                if (cnt == '0) state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                pend_wr   = wr_en;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        pend_vld_nxt = pend_wr ? 1'b1 : ((state == ST_IDLE) ? 1'b0 : pend_vld);
        busy_nxt     = (state_nxt != ST_IDLE) | pend_vld_nxt;
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd5) ? bcd_r[4*i +: 4] + 4'd3
                                                          : bcd_r[4*i +: 4];
        end
    end

    // Leading-zero blanking only considers the digits that are actually shown
    always_comb begin
        wide      = '0;
        dig_vec   = '0;
        blank_vec = '0;
        lit       = 1'b0;
        if (cur_dec) wide[BCD_W-1:0]  = bcd_r;
        else         wide[DATA_W-1:0] = data_r;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig_vec[4*i +: 4] = wide[4*i +: 4];
            lit               = lit | (wide[4*i +: 4] != 4'd0) | (i == 0);
            blank_vec[i]      = cur_blank & ~lit;
        end
    end

    assign ovf_dec = |(bcd_r >> DISP_W);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_to_seg7 #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_seg (
            .digit(dig_vec[4*g +: 4]),
            .blank(blank_vec[g]),
            .seg  (seg_vec[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r     <= '0;
            bcd_r      <= '0;
            cnt        <= '0;
            cur_dec    <= 1'b0;
            cur_blank  <= 1'b0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            pend_dec   <= 1'b0;
            pend_blank <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            hex_out    <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            if (ld) begin
                data_r    <= ld_data;
                bcd_r     <= '0;
                cur_dec   <= ld_dec;
                cur_blank <= ld_blank;
                cnt       <= CNT_W'(DATA_W - 1);
            end else if (state == ST_CONV) begin
                {bcd_r, data_r} <= {bcd_adj[BCD_W-2:0], data_r, 1'b0};
                cnt             <= cnt - 1'b1;
            end
            if (pend_wr) begin
                pend_data  <= wr_data;
                pend_dec   <= wr_dec;
                pend_blank <= blank_lz;
            end
            pend_vld <= pend_vld_nxt;
            busy     <= busy_nxt;
            done     <= (state == ST_UPDATE);
            if (state == ST_UPDATE) begin
                hex_out  <= seg_vec;
                overflow <= cur_dec & ovf_dec;
            end
        end
    end

endmodule

// File: tb/tb_io_hex_display.sv
// Scoreboard bench for io_hex_display: directed cases plus randomized writes
// checked against an arithmetic display model.
module tb_io_hex_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_dec = 1'b0;
    logic        blank_lz = 1'b0;
    logic [55:0] hex_out;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [55:0] seg;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [6:0] LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    io_hex_display #(
        .DATA_W(32),
        .NUM_DIGITS(8),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_dec(wr_dec),
        .blank_lz(blank_lz),
        .hex_out(hex_out),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] v, input bit dec, input bit blank, input int ecyc);
        exp_t   e;
        int     d[8];
        longint x;
        int     msd;
        x = longint'(v);
        for (int i = 0; i < 8; i++) begin
            if (dec) begin
                d[i] = int'(x % 10);
                x    = x / 10;
            end else begin
                d[i] = int'((v >> (4 * i)) & 32'hF);
            end
        end
        e.ovf = dec && (x != 0);
        msd = 0;
        for (int i = 0; i < 8; i++) if (d[i] != 0) msd = i;
        e.seg = '0;
        for (int i = 0; i < 8; i++)
            e.seg[7*i +: 7] = (blank && i > msd) ? 7'h7F : ~LUT[d[i]];
        e.cyc = ecyc;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hex_out", hex_out, e.seg);
                check("overflow", overflow, e.ovf);
                if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_write(input logic [31:0] d, input bit dec, input bit blank, output int e0);
        @(posedge clk);
        #1;
        wr_en    = 1'b1;
        wr_data  = d;
        wr_dec   = dec;
        blank_lz = blank;
        e0       = cyc + 1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wr_idle(input logic [31:0] d, input bit dec, input bit blank, output int e0);
        do_write(d, dec, blank, e0);
        sb.push_back(model(d, dec, blank, e0 + (dec ? 33 : 1)));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int e0;
        int n;
        logic [31:0] d;
        bit dec;
        bit bl;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hex_out", hex_out, {56{1'b1}});
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        rst_n = 1'b1;

        wr_idle(32'hDEADBEEF, 1'b0, 1'b0, e0);
        wait_idle();
        @(negedge clk);
        check("deadbeef_literal", hex_out,
              {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
        check("done_one_cycle", done, 1'b0);

        wr_idle(32'd12345, 1'b1, 1'b1, e0);
        n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 100);
        check("busy_cycles", n, 33);
        @(negedge clk);
        check("dec12345_literal", hex_out,
              {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});

        wr_idle(32'hFFFFFFFF, 1'b1, 1'b0, e0);
        wait_idle();
        wr_idle($urandom, 1'b0, 1'b0, e0);
        wait_idle();

        wr_idle(32'd0, 1'b1, 1'b1, e0);
        wait_idle();

        // Two HEX writes land mid-conversion: only the last one is shown
        wr_idle(32'd100, 1'b1, 1'b0, e0);
        do_write(32'h1, 1'b0, 1'b0, n);
        do_write(32'h2, 1'b0, 1'b0, n);
        sb.push_back(model(32'h2, 1'b0, 1'b0, e0 + 33 + 1 + 1));
        wait_idle();
        wait_idle();

        // Reset mid-conversion: no update may follow
        do_write(32'd987654, 1'b1, 1'b0, e0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hex_out", hex_out, {56{1'b1}});
        check("abort_busy", busy, 1'b0);
        check("abort_overflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check("abort_busy_after", busy, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int k;
            logic [31:0] pd;
            bit pdec;
            bit pbl;
            wait_idle();
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d = d & 32'h0000_0FFF;
            dec = 1'($urandom_range(0, 1));
            bl  = 1'($urandom_range(0, 1));
            wr_idle(d, dec, bl, e0);
            k = dec ? int'($urandom_range(0, 3)) : 0;
            pd = '0;
            pdec = 1'b0;
            pbl = 1'b0;
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                pd = $urandom;
                if ($urandom_range(0, 1) == 0) pd = pd & 32'h0000_00FF;
                pdec = 1'($urandom_range(0, 1));
                pbl  = 1'($urandom_range(0, 1));
                do_write(pd, pdec, pbl, n);
            end
            if (k > 0) sb.push_back(model(pd, pdec, pbl, e0 + 34 + (pdec ? 33 : 1)));
            wait_idle();
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
